// File: rtl/paillier_stream_adapter_if.sv
// Host-side word bus for the Paillier stream adapter:
// operand beats in, result beats out, status pulses.
interface paillier_stream_adapter_if #(
    parameter int DATA_WIDTH = 128
);
    logic [3:0]            mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  done;
    logic                  err;

    modport master (
        output mode, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last, done, err
    );

    modport slave (
        input  mode, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last, done, err
    );
endinterface

// File: rtl/paillier_stream_adapter.sv
// Word-serial loader/unloader around the Paillier core.
// Optional WAIT watchdog: define PAILLIER_STREAM_TIMEOUT_EN.
module paillier_stream_adapter #(
    parameter int RSA_WIDTH      = 4096,
    parameter int DATA_WIDTH     = 128,
    parameter int DATA_NUMBER    = 32,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                 clk,
    input  logic                 rst,
    paillier_stream_adapter_if.slave bus,
    output logic                 core_go,
    output logic [RSA_WIDTH-1:0] core_m,
    output logic [RSA_WIDTH-1:0] core_r,
    output logic [RSA_WIDTH-1:0] core_c,
    output logic [RSA_WIDTH-1:0] core_c1,
    output logic [RSA_WIDTH-1:0] core_c2,
    output logic [3:0]           core_mode,
    input  logic                 core_done,
    input  logic [RSA_WIDTH-1:0] core_result
);
    localparam int IW = $clog2(DATA_NUMBER + 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_NUMBER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        widx;
    logic [RSA_WIDTH-1:0] buf_q;
    logic                 done_q;
    logic                 err_q;
    logic [3:0]           sel_mode;
    logic                 mode_ok;
    logic                 ld_en;
    logic                 out_fire;
    logic                 tmo_hit;
    logic                 tmo_fire;
    logic                 clr_ops;

`ifdef PAILLIER_STREAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = (state_q == S_WAIT) &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles, held at zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_WAIT) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign mode_ok = (bus.mode == 4'b0001) ||
                     (bus.mode == 4'b0010) ||
                     (bus.mode == 4'b0100) ||
                     (bus.mode == 4'b1000);

    assign sel_mode = (state_q == S_IDLE) ? bus.mode : core_mode;
    assign widx     = (state_q == S_IDLE) ? '0 : idx_q;

    assign ld_en = bus.in_valid &&
                   ((state_q == S_IDLE && mode_ok) ||
                    (state_q == S_LOAD));

    assign out_fire = (state_q == S_UNLOAD) && bus.out_ready;
    assign tmo_fire = (state_q == S_WAIT) && !core_done && tmo_hit;
    assign clr_ops  = tmo_fire || (out_fire && idx_q == LAST);

    // Handshake outputs come from registered state only;
    // in_ready is additionally held low while reset is asserted.
    assign bus.in_ready  = !rst &&
                           (state_q == S_IDLE || state_q == S_LOAD);
    assign bus.out_valid = (state_q == S_UNLOAD);
    assign bus.out_last  = (state_q == S_UNLOAD) && (idx_q == LAST);
    assign bus.out_data  = (state_q == S_UNLOAD) ?
                           buf_q[DATA_WIDTH*idx_q +: DATA_WIDTH] : '0;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign core_go       = (state_q == S_START);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && mode_ok) begin
                    state_d = (DATA_NUMBER == 1) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid && idx_q == LAST) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_UNLOAD;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_UNLOAD: begin
                if (bus.out_ready && idx_q == LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Beat index, status pulses, result buffer and operand lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            buf_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            core_mode <= 4'b0000;
            core_m    <= '0;
            core_r    <= '0;
            core_c    <= '0;
            core_c1   <= '0;
            core_c2   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (state_q == S_IDLE && bus.in_valid) begin
                if (mode_ok) begin
                    core_mode <= bus.mode;
                    idx_q     <= IW'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (state_q == S_LOAD && bus.in_valid) begin
                idx_q <= idx_q + IW'(1);
            end

            if (state_q == S_WAIT && core_done) begin
                buf_q <= core_result;
                idx_q <= '0;
            end

            if (tmo_fire) begin
                err_q <= 1'b1;
                idx_q <= '0;
            end

            if (out_fire) begin
                if (idx_q == LAST) begin
                    done_q <= 1'b1;
                    idx_q  <= '0;
                    buf_q  <= '0;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end

            if (clr_ops) begin
                core_m  <= '0;
                core_r  <= '0;
                core_c  <= '0;
                core_c1 <= '0;
                core_c2 <= '0;
            end else if (ld_en) begin
                unique case (1'b1)
                    sel_mode[0]: begin
                        core_m[DATA_WIDTH*widx +: DATA_WIDTH] <= bus.in_a;
                        core_r[DATA_WIDTH*widx +: DATA_WIDTH] <= bus.in_b;
                    end
                    sel_mode[1]: begin
                        core_c[DATA_WIDTH*widx +: DATA_WIDTH] <= bus.in_a;
                    end
                    sel_mode[2]: begin
                        core_c1[DATA_WIDTH*widx +: DATA_WIDTH] <= bus.in_a;
                        core_c2[DATA_WIDTH*widx +: DATA_WIDTH] <= bus.in_b;
                    end
                    sel_mode[3]: begin
                        core_m[DATA_WIDTH*widx +: DATA_WIDTH] <= bus.in_a;
                        core_c[DATA_WIDTH*widx +: DATA_WIDTH] <= bus.in_b;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/paillier_stream_adapter.md
# paillier_stream_adapter

Word-serial front end for the Paillier datapath. It collects DATA_NUMBER input beats of DATA_WIDTH bits into RSA_WIDTH-bit operands, selected by a one-hot operation mode. It then launches the core with a one-cycle go pulse, captures the core result, and streams it back out with valid/ready back-pressure. It sits between the host word bus and paillier_demo_overall_top, which it does not instantiate; core ports are exposed. It supersedes the fixed-rate loader with a handshaked, back-pressurable, error-reporting interface.

## Interface
- RSA_WIDTH, 4096, operand/result width; must equal DATA_WIDTH*DATA_NUMBER
- DATA_WIDTH, 128, beat width
- DATA_NUMBER, 32, beats per operand; minimum 1
- TIMEOUT_CYCLES, 2**20, watchdog limit in WAIT (used only with PAILLIER_STREAM_TIMEOUT_EN)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  4  one-hot op: 0001 encry, 0010 decry, 0100 homo_add, 1000 homo_mul
- in_valid / in_ready  in / out  1  input beat handshake
- in_a, in_b  in  DATA_WIDTH  lane A / lane B beat
- out_valid / out_ready  out / in  1  output beat handshake
- out_data  out  DATA_WIDTH  result beat
- out_last  out  1  marks final result beat
- done  out  1  one-cycle pulse after the last result beat is accepted
- err  out  1  one-cycle pulse on illegal mode or timeout
- core_go  out  1  one-cycle start pulse to the core
- core_m, core_r, core_c, core_c1, core_c2  out  RSA_WIDTH  operands to the core
- core_mode  out  4  latched mode to the core
- core_done  in  1  core completion strobe
- core_result  in  RSA_WIDTH  core result, valid when core_done=1

## Operation
- States: IDLE, LOAD, START, WAIT, UNLOAD.
- Beat index idx is $clog2(DATA_NUMBER+1) bits. Beat k occupies bits [DATA_WIDTH*k +: DATA_WIDTH], k=0 first (LSW first).
- Lane mapping:
  - encry: A→m, B→r
  - decry: A→c, B ignored
  - homo_add: A→c1, B→c2
  - homo_mul: A→m, B→c
  - Unmapped operand registers stay 0.
- IDLE:
  - in_ready=1.
  - On an accepted beat with a legal one-hot mode: latch mode, store beat 0, idx←1, go to LOAD (START if DATA_NUMBER=1).
  - On an illegal mode (not exactly one bit set): drop the beat, pulse err, stay in IDLE.
- LOAD:
  - in_ready=1; each accepted beat is stored at idx, then idx++.
  - The accepted beat with idx=DATA_NUMBER-1 moves the FSM to START.
  - mode is ignored in LOAD; the latched value governs.
- START: core_go=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - in_ready=0.
  - On core_done=1: capture core_result into the result buffer, idx←0, go to UNLOAD.
- UNLOAD:
  - out_valid=1, out_data=buffer beat idx.
  - out_last=1 when idx=DATA_NUMBER-1.
  - idx advances only when out_ready=1.
  - When the last beat is accepted: pulse done next cycle, zero all operand registers and the buffer, go to IDLE.
- core_done outside WAIT is ignored.

## Timing
- Reset values: in_ready=0 during reset, 1 the first cycle after; out_valid=0, out_last=0, done=0, err=0, core_go=0, all core_* operands=0, core_mode=0, out_data=0.
- Reset asserted mid-operation aborts any state to IDLE on the next edge; no done or err is issued.
- in_ready, out_valid and out_last are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Latency:
  - Last input beat accepted at edge t → core_go high in cycle t+1.
  - core_done sampled at edge u → first out_valid in cycle u+1.
  - Last output beat accepted at edge v → done high in cycle v+1, in_ready high in cycle v+1.
- Minimum transaction length is DATA_NUMBER + 2 + core latency + DATA_NUMBER cycles.
- out_data holds stable while out_valid=1 and out_ready=0.

## Configuration
- PAILLIER_STREAM_TIMEOUT_EN defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without core_done: pulse err, zero operands, return to IDLE.
  - core_done on the same cycle as the timeout wins.
- PAILLIER_STREAM_TIMEOUT_EN undefined: no counter; WAIT persists until core_done; err pulses only for illegal mode.

## Test plan
- homo_add, DATA_NUMBER=32, in_a beats k→k+1, in_b beats k→0x100+k, stub core returns c1+c2 → core_c1 word k=k+1, core_c2 word k=0x100+k, one core_go pulse, 32 out beats = 0x101+2k, out_last on beat 31, done one cycle later.
- decry, out_ready toggling 1/0 every cycle → out_data stable across stalls, 32 beats in order, done exactly once.
- mode=4'b0011 with in_valid=1 → beat dropped, err pulses 1 cycle, state IDLE, core_go stays 0.
- mode changed from encry to homo_mul at beat 5 of LOAD → operands still routed as encry (m, r), core_mode=0001.
- rst asserted in UNLOAD at beat 10 → next cycle out_valid=0, in_ready=1, operands 0, no done.
- TIMEOUT_EN with TIMEOUT_CYCLES=16 and core_done never asserted → err pulses 16 cycles after WAIT entry, returns to IDLE; without macro → remains in WAIT for 1000 cycles.
